// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default sizes, the index-width
// derivation and the hardwired zero-register index. Decode and write-back
// import this package too, so the defaults live here in one place.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ZERO_IDX     = 0;

  // Register index width for a power-of-two register count (minimum 1 bit)
  function automatic int addr_w(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-back scoreboard: one pending bit per register, RAW/WAW hazard
// detection for the issuing instruction, claim/clear priority and a
// registered population count of the pending vector.
// Optional debug readout of one pending bit under REGFILE_DBG_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = addr_w(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_eff,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              iss_rd_used,
  input  logic              iss_rs1_used,
  input  logic              iss_rs2_used,
  output logic              iss_ready,
`ifdef REGFILE_DBG_EN
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_pend,
`endif
  output logic [ADDR_W:0]   pend_cnt
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                src1_hz;
  logic                src2_hz;
  logic                dst_hz;
  logic                claim;

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + (ADDR_W+1)'(v[i]);
    end
    return cnt;
  endfunction

  // Hazards: a same-cycle write-back to the register resolves its pending bit
  always_comb begin
    src1_hz   = iss_rs1_used & pending[ra1]    & ~(we_eff && (waddr == ra1));
    src2_hz   = iss_rs2_used & pending[ra2]    & ~(we_eff && (waddr == ra2));
    dst_hz    = iss_rd_used  & pending[iss_rd] & ~(we_eff && (waddr == iss_rd));
    iss_ready = ~(src1_hz | src2_hz | dst_hz);
    claim     = iss_valid & iss_ready & iss_rd_used &
                ~((ZERO_REG != 0) && (iss_rd == ADDR_W'(ZERO_IDX)));
  end

  // Next pending vector: clear on write-back, then a claim on the same register wins
  always_comb begin
    pending_nxt = pending;
    if (we_eff) pending_nxt[waddr] = 1'b0;
    if (claim)  pending_nxt[iss_rd] = 1'b1;
  end

  // Pending bits and their count update together so the count is always exact
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= popcount(pending_nxt);
    end
  end

`ifdef REGFILE_DBG_EN
  // Registered debug view of one pending bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dbg_pend <= 1'b0;
    else      dbg_pend <= pending[dbg_addr];
  end
`endif

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-first bypass on two read ports, one write-back
// port and an integrated scoreboard for issue stalls.
// Build option: define REGFILE_DBG_EN to add the dbg_addr/dbg_data/dbg_pend
// registered debug readout (no bypass on dbg_data).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = addr_w(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              iss_rd_used,
  input  logic              iss_rs1_used,
  input  logic              iss_rs2_used,
  output logic              iss_ready,
`ifdef REGFILE_DBG_EN
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_pend,
`endif
  output logic [ADDR_W:0]   pend_cnt
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              we_eff;

  // Writes to the hardwired zero register are dropped entirely
  assign we_eff = we & ~((ZERO_REG != 0) && (waddr == ADDR_W'(ZERO_IDX)));

  // Storage array; only written on an effective write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we_eff) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: write-first bypass, zero register forced to 0
  always_comb begin
    rd1 = (we_eff && (waddr == ra1)) ? wdata : regs[ra1];
    rd2 = (we_eff && (waddr == ra2)) ? wdata : regs[ra2];
    if ((ZERO_REG != 0) && (ra1 == ADDR_W'(ZERO_IDX))) rd1 = '0;
    if ((ZERO_REG != 0) && (ra2 == ADDR_W'(ZERO_IDX))) rd2 = '0;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .we_eff       (we_eff),
    .waddr        (waddr),
    .ra1          (ra1),
    .ra2          (ra2),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .iss_rd_used  (iss_rd_used),
    .iss_rs1_used (iss_rs1_used),
    .iss_rs2_used (iss_rs2_used),
    .iss_ready    (iss_ready),
`ifdef REGFILE_DBG_EN
    .dbg_addr     (dbg_addr),
    .dbg_pend     (dbg_pend),
`endif
    .pend_cnt     (pend_cnt)
  );

`ifdef REGFILE_DBG_EN
  // Registered debug view of the stored value (bypass deliberately not applied)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dbg_data <= '0;
    else      dbg_data <= regs[dbg_addr];
  end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default build, 32 x 32, zero register on).
// A behavioural model (value array + pending flags) predicts every output.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        iss_rd_used = 1'b0;
  logic        iss_rs1_used = 1'b0;
  logic        iss_rs2_used = 1'b0;
  logic        iss_ready;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int fails  = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  regfile_sb dut (
    .clk          (clk),
    .rst          (rst),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .ra1          (ra1),
    .ra2          (ra2),
    .rd1          (rd1),
    .rd2          (rd2),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .iss_rd_used  (iss_rd_used),
    .iss_rs1_used (iss_rs1_used),
    .iss_rs2_used (iss_rs2_used),
    .iss_ready    (iss_ready),
    .pend_cnt     (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_write_eff();
    return we && (waddr != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_write_eff() && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic bit m_busy(input logic [4:0] a);
    return m_pend[a] && !(m_write_eff() && waddr == a);
  endfunction

  function automatic bit m_ready();
    return !((iss_rs1_used && m_busy(ra1)) || (iss_rs2_used && m_busy(ra2)) ||
             (iss_rd_used && m_busy(iss_rd)));
  endfunction

  function automatic int m_count();
    int n = 0;
    foreach (m_pend[i]) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic m_reset();
    foreach (m_regs[i]) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic set_in(input bit w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input bit iv, input logic [4:0] rdi,
                        input bit rdu, input bit r1u, input bit r2u);
    we = w; waddr = wa; wdata = wd; ra1 = a1; ra2 = a2;
    iss_valid = iv; iss_rd = rdi; iss_rd_used = rdu;
    iss_rs1_used = r1u; iss_rs2_used = r2u;
  endtask

  // Check all outputs against the model, then advance one clock and update the model
  task automatic tick();
    bit rdy;
    #1;
    rdy = m_ready();
    chk("rd1", rd1, m_read(ra1));
    chk("rd2", rd2, m_read(ra2));
    chk("iss_ready", {31'd0, iss_ready}, {31'd0, rdy});
    chk("pend_cnt", {26'd0, pend_cnt}, m_count());
    @(posedge clk);
    if (rst) begin
      if (m_write_eff()) begin
        m_regs[waddr] = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (iss_valid && rdy && iss_rd_used && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    // Reset state
    #2;
    chk("reset_rd1", rd1, 32'd0);
    chk("reset_ready", {31'd0, iss_ready}, 32'd1);
    chk("reset_cnt", {26'd0, pend_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Write with same-cycle bypass, then the stored value
    set_in(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0);
    #1 chk("bypass_rd1", rd1, 32'hDEADBEEF);
    tick();
    set_in(0, 0, 0, 5, 5, 0, 0, 0, 0, 0);
    #1 chk("stored_rd1", rd1, 32'hDEADBEEF);
    tick();

    // Zero register: write and claim are both ignored
    set_in(1, 0, 32'h1234, 0, 0, 1, 0, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("x0_rd1", rd1, 32'd0);
    chk("x0_cnt", {26'd0, pend_cnt}, 32'd0);
    tick();

    // RAW stall and release
    set_in(0, 0, 0, 0, 0, 1, 7, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 7, 0, 1, 0, 0, 1, 0);
    #1 chk("raw_stall", {31'd0, iss_ready}, 32'd0);
    chk("raw_cnt1", {26'd0, pend_cnt}, 32'd1);
    tick();
    set_in(1, 7, 32'h55, 7, 0, 1, 0, 0, 1, 0);
    #1 chk("raw_release", {31'd0, iss_ready}, 32'd1);
    chk("raw_rd1", rd1, 32'h55);
    tick();
    set_in(0, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    #1 chk("raw_cnt0", {26'd0, pend_cnt}, 32'd0);
    tick();

    // Claim/clear collision: the new claim keeps x3 pending
    set_in(0, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    tick();
    set_in(1, 3, 32'hA5A5, 0, 0, 1, 3, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 3, 0, 1, 0, 0, 1, 0);
    #1 chk("coll_cnt", {26'd0, pend_cnt}, 32'd1);
    chk("coll_pending", {31'd0, iss_ready}, 32'd0);
    tick();
    set_in(1, 3, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Capacity: fill x1..x31, then drain in reverse order
    for (int i = 1; i < 32; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 5'(i), 1, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("cap_full", {26'd0, pend_cnt}, 32'd31);
    for (int i = 31; i >= 1; i--) begin
      set_in(1, 5'(i), 32'(i * 3), 5'(i), 5'(i), 0, 0, 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("cap_empty", {26'd0, pend_cnt}, 32'd0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
             5'($urandom), 5'($urandom),
             1'($urandom_range(0, 1)), 5'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      tick();
    end

    // Asynchronous reset mid-run with pending bits set
    for (int i = 1; i < 5; i++) begin
      set_in(1, 5'(i + 8), 32'hFFFF_0000 + 32'(i), 0, 0, 1, 5'(i), 1, 0, 0);
      tick();
    end
    set_in(1, 9, 32'h77, 9, 9, 1, 2, 1, 0, 0);
    #2 rst = 1'b0;
    m_reset();
    #1;
    chk("areset_cnt", {26'd0, pend_cnt}, 32'd0);
    chk("areset_ready", {31'd0, iss_ready}, 32'd1);
    set_in(0, 0, 0, 9, 9, 0, 0, 0, 0, 0);
    #1 chk("areset_rd1", rd1, 32'd0);
    // Write and claim during reset are discarded
    set_in(1, 9, 32'h77, 9, 9, 1, 2, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      set_in(0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with an integrated write-back scoreboard, successor to the fixed 32×32 register file in the CPU datapath. It provides two combinational read ports with write-first bypass and one write port, and keeps a per-register pending bit for in-flight results. It produces an issue-ready signal so the decode stage can stall on RAW/WAW hazards. It sits between decode (read and issue) and write-back (write and clear).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, register count; power of two, ≥ 2
- ADDR_W, $clog2(NUM_REGS), register index width (derived; do not override)
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never pending

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low; clears every register and every pending bit
- we  in  1  write-back strobe
- waddr  in  ADDR_W  write-back destination
- wdata  in  DATA_W  write-back data
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  read data, combinational
- iss_valid  in  1  decode presents an instruction
- iss_rd  in  ADDR_W  destination to claim
- iss_rd_used, iss_rs1_used, iss_rs2_used  in  1  the operand or destination is real
- iss_ready  out  1  no hazard; claim accepted this cycle
- pend_cnt  out  ADDR_W+1  number of pending registers

## Operation
- Effective write: we=1 and not (ZERO_REG=1 and waddr=0). On an effective write, regs[waddr]←wdata and pending[waddr]←0.
- Read: rdN = (effective write and waddr==raN) ? wdata : regs[raN]. When ZERO_REG=1 and raN=0, rdN=0.
- Hazard per source: srcN_hz = iss_rsN_used & pending[raN] & ~(effective write to raN). The issue source addresses are ra1 and ra2.
- Destination hazard: dst_hz = iss_rd_used & pending[iss_rd] & ~(effective write to iss_rd).
- iss_ready = ~(src1_hz | src2_hz | dst_hz). This signal is independent of iss_valid.
- Claim: iss_valid & iss_ready & iss_rd_used & not (ZERO_REG=1 and iss_rd=0) sets pending[iss_rd].
- If a claim and a clear target the same register in the same cycle, the set wins: the new producer owns it.
- pend_cnt is a registered popcount of pending. It is updated in the same edge as the pending bits, so it is exact every cycle and never wraps (maximum NUM_REGS).
- A write to a non-pending register is legal: the data is written and the pending bit stays 0.

## Timing
- Reset values: all regs 0, all pending 0, pend_cnt 0. The outputs are therefore rd1=rd2=0, iss_ready=1, pend_cnt=0.
- rst asserted mid-operation clears state immediately, regardless of the clock. A claim or write in the reset cycle is discarded. State updates resume on the first rising edge after rst deasserts.
- Read latency: 0 cycles; bypass makes same-cycle write-back data visible.
- Write latency: 1 cycle; regs read the new value from the next edge onward.
- Issue handshake is single-cycle: the claim commits on the edge where iss_valid & iss_ready are both 1. Decode holds the instruction while iss_ready=0.
- Combinational path: we/waddr → iss_ready. Write-back must drive these from flops.

## Configuration
- REGFILE_DBG_EN defined: adds ports dbg_addr (in, ADDR_W), dbg_data (out, DATA_W) and dbg_pend (out, 1).
  - dbg_data and dbg_pend are registered copies of regs[dbg_addr] and pending[dbg_addr], with 1-cycle latency.
  - dbg_data does not use the bypass.
  - Reset value 0 for both.
- Macro undefined: these ports and their flops do not exist, and the core behaviour is identical.

## Structure
- Shared package regfile_pkg holds the DATA_W and NUM_REGS defaults, the ADDR_W derivation function and the zero-register index constant. The package is reused by decode and write-back.
- One sub-module, regfile_scoreboard, owns the pending vector, hazard logic, claim/clear priority and pend_cnt.
- The top level holds the storage array, the bypass muxes and the debug port.

## Test plan
- Reset: drive rst=0 mid-run with pending bits set, then release → rd1=rd2=0, pend_cnt=0, iss_ready=1, and all 32 registers read 0.
- Write/read with bypass: we=1, waddr=5, wdata=0xDEADBEEF, ra1=5 in the same cycle → rd1=0xDEADBEEF. Next cycle, with we=0 → rd1 still 0xDEADBEEF.
- Zero register: write 0x1234 to x0, and claim iss_rd=0 → rd1(ra1=0)=0, pend_cnt remains 0.
- RAW stall and release:
  - Claim x7, then present ra1=7 with iss_rs1_used=1 → iss_ready=0.
  - In the cycle write-back writes x7=0x55 → iss_ready=1 and rd1=0x55, and pend_cnt goes 1→0.
- Claim/clear collision: x3 is pending; in one cycle, write-back clears x3 while a new issue claims iss_rd=3 → pending[3]=1 and pend_cnt unchanged at 1.
- Capacity: claim x1..x31 on consecutive cycles with no write-back → pend_cnt=31. Then write them back in reverse order → pend_cnt decrements by 1 per cycle to 0.
